// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - memory-mapped SPI master (mode 0, MSB first) with status and irq
module spi_master_ctrl #(
  parameter logic [12:0] BASE_ADDR = 13'h0100,
  parameter int          FRAME_W   = 16,
  parameter int          DIV_W     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [12:0] adr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        sel,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_cs_n,
  output logic        irq
);

  localparam int BC_W = $clog2(FRAME_W + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_HIGH  = 3'd2;
  localparam logic [2:0] S_LOW   = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  logic [2:0]         state;
  logic [DIV_W-1:0]   timer;
  logic [DIV_W-1:0]   clkdiv;
  logic [BC_W-1:0]    bitcount;
  logic [FRAME_W-1:0] shreg;
  logic [FRAME_W-1:0] rxdata;
  logic [15:0]        txdata;
  logic               sample;
  logic               ie;
  logic               done;
  logic               overrun;
  logic               busy;

  logic [12:0] offset;
  logic        wr_ctrl;
  logic        wr_tx;
  logic        wr_stat;
  logic        phase_end;
  logic        last_bit;

  // Window decode: the subtraction wraps, so addresses below the base fall outside too.
  assign offset    = adr - BASE_ADDR;
  assign sel       = (offset < 13'd4);
  assign wr_ctrl   = we & sel & (offset[1:0] == 2'd0);
  assign wr_tx     = we & sel & (offset[1:0] == 2'd1);
  assign wr_stat   = we & sel & (offset[1:0] == 2'd3);
  assign phase_end = (timer == '0);
  assign last_bit  = (bitcount == BC_W'(FRAME_W));
  assign irq       = done & ie;

  // Combinational register read-back; zero outside the window.
  always_comb begin
    rdata = '0;
    if (sel) begin
      case (offset[1:0])
        2'd0: begin
          rdata[0]          = ie;
          rdata[DIV_W+7:8]  = clkdiv;
        end
        2'd1:    rdata = txdata;
        2'd2:    rdata[FRAME_W-1:0] = rxdata;
        default: rdata[2:0] = {busy, overrun, done};
      endcase
    end
  end

  // Register file, half-period timer and frame sequencer.
  // Received bits are held in 'sample' at the rising edge and shifted in at the
  // following falling edge, so the outgoing LSBs are never overwritten early.
  // After the last rising edge a full low half-period precedes HOLD, giving
  // 2*FRAME_W+2 phases per frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      timer    <= '0;
      clkdiv   <= '0;
      bitcount <= '0;
      shreg    <= '0;
      rxdata   <= '0;
      txdata   <= '0;
      sample   <= 1'b0;
      ie       <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
      busy     <= 1'b0;
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b0;
      spi_cs_n <= 1'b1;
    end else begin
      if (wr_ctrl) begin
        ie     <= wdata[0];
        clkdiv <= wdata[DIV_W+7:8];
      end
      if (wr_stat && wdata[0]) done    <= 1'b0;
      if (wr_stat && wdata[1]) overrun <= 1'b0;
      if (wr_tx && (state != S_IDLE)) overrun <= 1'b1;

      if ((state != S_IDLE) && !phase_end) timer <= timer - 1'b1;

      case (state)
        S_IDLE: begin
          if (wr_tx) begin
            shreg    <= wdata[FRAME_W-1:0];
            txdata   <= wdata;
            done     <= 1'b0;
            busy     <= 1'b1;
            spi_cs_n <= 1'b0;
            spi_mosi <= wdata[FRAME_W-1];
            bitcount <= '0;
            timer    <= clkdiv;
            state    <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (phase_end) begin
            spi_sclk <= 1'b1;
            sample   <= spi_miso;
            bitcount <= bitcount + BC_W'(1);
            timer    <= clkdiv;
            state    <= S_HIGH;
          end
        end
        S_HIGH: begin
          if (phase_end) begin
            spi_sclk <= 1'b0;
            shreg    <= {shreg[FRAME_W-2:0], sample};
            if (!last_bit) spi_mosi <= shreg[FRAME_W-2];
            timer    <= clkdiv;
            state    <= S_LOW;
          end
        end
        S_LOW: begin
          if (phase_end) begin
            timer <= clkdiv;
            if (last_bit) begin
              state <= S_HOLD;
            end else begin
              spi_sclk <= 1'b1;
              sample   <= spi_miso;
              bitcount <= bitcount + BC_W'(1);
              state    <= S_HIGH;
            end
          end
        end
        S_HOLD: begin
          if (phase_end) begin
            spi_cs_n <= 1'b1;
            spi_mosi <= 1'b0;
            rxdata   <= shreg;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
